mips_uart_tx_port: RTL

//   Memory-mapped UART transmitter on the MIPS MEM stage, downstream of EX/MEM (EX_MEM.ALUResult/ReadData2/MemWrite/MemRead).

---
 rtl/mips_uart_tx_port_if.sv | 20 ++
 rtl/mips_uart_tx_port.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mips_uart_tx_port_if.sv
// MEM-stage bus seen by the UART transmitter port: EX/MEM strobes, address and
// store data in, zero-latency load data and decode hit out.
interface mips_uart_tx_port_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IOHit;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  ReadData, IOHit
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output ReadData, IOHit
  );
endinterface

// File: rtl/mips_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a small
// FIFO, a serializer drains it onto TxD, and loads from STATUS report state.
module mips_uart_tx_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0020,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mips_uart_tx_port_if.slave  bus,
  output logic                TxD,
  output logic                TxBusy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

  txState_e          state_q, state_d;
  logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              txd_q, txd_d;
  logic [7:0]        fifoMem [FIFO_DEPTH];

  logic        fifoEmpty, fifoFull, baudDone;
  logic        popEn, pushReq, pushEn, statusWr;
  logic [31:0] statusWord;
  logic        unusedWdata;

  assign fifoEmpty   = (count_q == '0);
  assign fifoFull    = (count_q == DEPTH_CNT);
  assign baudDone    = (baudCnt_q == BAUD_LAST);
  assign unusedWdata = ^bus.WriteData[31:8];
  assign TxD         = txd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      txd_q      <= txd_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (pushEn) fifoMem[wrPtr_q] <= bus.WriteData[7:0];
  end

  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    popEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          popEn     = 1'b1;
          shift_d   = fifoMem[rdPtr_q];
          baudCnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baudDone) begin
          baudCnt_d = '0;
          bitIdx_d  = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudDone) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bitIdx_d  = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = STOP;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (baudDone) begin
          baudCnt_d = '0;
          if (!fifoEmpty) begin
            popEn   = 1'b1;
            shift_d = fifoMem[rdPtr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pushReq  = bus.MemWrite && (bus.Address == TXDATA_ADDR);
    statusWr = bus.MemWrite && (bus.Address == STATUS_ADDR);
    pushEn   = pushReq && (!fifoFull || popEn);

    rdPtr_d = popEn  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    wrPtr_d = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);

    overflow_d = overflow_q;
    if (statusWr && bus.WriteData[3]) overflow_d = 1'b0;
    if (pushReq && fifoFull && !popEn) overflow_d = 1'b1;
  end

  // TxD is registered from the next state so the line level tracks the state register.
  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    TxBusy     = (state_q != IDLE) || !fifoEmpty;
    statusWord = {24'b0, 4'(count_q), overflow_q, (state_q != IDLE), fifoEmpty, fifoFull};

    bus.IOHit    = (bus.MemRead || bus.MemWrite) &&
                   ((bus.Address == TXDATA_ADDR) || (bus.Address == STATUS_ADDR));
    bus.ReadData = (bus.MemRead && (bus.Address == STATUS_ADDR)) ? statusWord : 32'b0;
  end

endmodule
